fp_mul_pipe: RTL and testbench

Parametrised, pipelined unsigned multiplier with valid/ready flow control, the successor of the 8×8 combinational field multiplier in the Barrett-reduction datapath. It accepts one operand pair per cycle and returns the full-width product after a configurable number of register stages. Back-pressure stalls the pipeline without dropping or duplicating results. It feeds the Barrett reduction stage and the NTT butterfly units wherever a registered product is needed at high clock rates.

---
 rtl/fp_mul_pipe.sv | 65 ++++++
 tb/tb_fp_mul_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined unsigned WIDTH x WIDTH multiplier with valid/ready flow control; tag sideband when FP_MUL_PIPE_TAG_EN is defined
module fp_mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
`ifdef FP_MUL_PIPE_TAG_EN
  input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]     out_tag,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_c,
  output logic                 busy
);
  localparam int PW = 2 * WIDTH;
  if (WIDTH < 2 || STAGES < 1 || TAG_W < 1) begin : g_param_check
    $error("fp_mul_pipe: WIDTH>=2, STAGES>=1, TAG_W>=1 required");
  end
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [PW-1:0]     d [STAGES];
  // A stage can advance unless it and every stage after it is full while the consumer stalls;
  // written as a reduction rather than a chain so each bit depends only on v and out_ready.
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign adv[g] = out_ready || !(&v[STAGES-1:g]);
  end
  // Full product is formed once at stage 0 and then shifted; valid bits move on advance, data loads only on incoming valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      if (adv[0]) v[0] <= in_valid;
      if (adv[0] && in_valid) d[0] <= PW'(in_a) * PW'(in_b);
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) v[i] <= v[i-1];
        if (adv[i] && v[i-1]) d[i] <= d[i-1];
      end
    end
  end
`ifdef FP_MUL_PIPE_TAG_EN
  logic [TAG_W-1:0] t [STAGES];
  // Tag follows its operand pair under the same load/hold rules as the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) t[i] <= '0;
    end else begin
      if (adv[0] && in_valid) t[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) if (adv[i] && v[i-1]) t[i] <= t[i-1];
    end
  end
  assign out_tag = t[STAGES-1];
`endif
  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_c     = d[STAGES-1];
  assign busy      = |v;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed table-driven and sequence checks for fp_mul_pipe (STAGES=3 and STAGES=1 instances)
module tb_fp_mul_pipe;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_c;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [15:0] in_a1, in_b1;
  logic [31:0] out_c1;
`ifdef FP_MUL_PIPE_TAG_EN
  logic [3:0]  in_tag, out_tag, in_tag1, out_tag1;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
`ifdef FP_MUL_PIPE_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );

  fp_mul_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1),
`ifdef FP_MUL_PIPE_TAG_EN
    .in_tag(in_tag1), .out_tag(out_tag1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_c(out_c1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } vec_t;

  localparam int N = 12;
  vec_t tbl [N];

  initial begin
    tbl[0]  = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[1]  = '{8'h03, 8'h05, 16'h000F};
    tbl[2]  = '{8'h10, 8'h10, 16'h0100};
    tbl[3]  = '{8'h00, 8'hAB, 16'h0000};
    tbl[4]  = '{8'h02, 8'h02, 16'h0004};
    tbl[5]  = '{8'h07, 8'h06, 16'h002A};
    tbl[6]  = '{8'h80, 8'h02, 16'h0100};
    tbl[7]  = '{8'h0F, 8'h0F, 16'h00E1};
    tbl[8]  = '{8'h01, 8'hFF, 16'h00FF};
    tbl[9]  = '{8'hAA, 8'h55, 16'h3872};
    tbl[10] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[11] = '{8'h80, 8'h80, 16'h4000};
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
    in_valid1 = 0; in_a1 = 0; in_b1 = 0; out_ready1 = 1;
`ifdef FP_MUL_PIPE_TAG_EN
    in_tag = 0; in_tag1 = 0;
`endif
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready_s1", in_ready1, 1);
    tick();

    in_a = 8'hFF; in_b = 8'hFF; in_valid = 1;
    tick();
    in_valid = 0;
    chk("single_busy1", busy, 1);
    chk("single_early_valid", out_valid, 0);
    tick();
    chk("single_busy2", busy, 1);
    chk("single_early_valid2", out_valid, 0);
    tick();
    chk("single_out_valid", out_valid, 1);
    chk("single_out_c", out_c, 16'hFE01);
    chk("single_busy3", busy, 1);
    tick();
    chk("single_drained", out_valid, 0);
    chk("single_idle_busy", busy, 0);

    for (int k = 0; k < N + 2; k++) begin
      in_valid = k < N;
      if (k < N) begin
        in_a = tbl[k].a; in_b = tbl[k].b;
`ifdef FP_MUL_PIPE_TAG_EN
        in_tag = 4'(k);
`endif
      end
      #1 chk("stream_in_ready", in_ready, 1);
      tick();
      if (k >= 2) begin
        chk("stream_out_valid", out_valid, 1);
        chk("stream_out_c", out_c, tbl[k-2].c);
`ifdef FP_MUL_PIPE_TAG_EN
        chk("stream_out_tag", out_tag, 4'(k - 2));
`endif
      end
    end
    in_valid = 0;
    tick();
    chk("stream_drained", out_valid, 0);

    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_a = 8'(k + 2); in_b = 8'(k + 2); in_valid = 1;
      #1 chk("fill_in_ready", in_ready, 1);
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_c", out_c, 16'h0004);
    in_a = 8'h09; in_b = 8'h09;
    repeat (2) tick();
    chk("stall_hold_c", out_c, 16'h0004);
    chk("stall_in_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    #1 chk("full_xfer_in_ready", in_ready, 1);
    tick();
    chk("drain1_valid", out_valid, 1);
    chk("drain1_c", out_c, 16'h0009);
    tick();
    chk("drain2_valid", out_valid, 1);
    chk("drain2_c", out_c, 16'h0010);
    tick();
    chk("drain_end_valid", out_valid, 0);
    chk("drain_end_busy", busy, 0);

    out_ready = 0;
    in_a = 8'h05; in_b = 8'h05; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (2) tick();
    chk("bubble_head_valid", out_valid, 1);
    chk("bubble_head_c", out_c, 16'h0019);
    in_a = 8'h06; in_b = 8'h06; in_valid = 1;
    #1 chk("bubble_accept1", in_ready, 1);
    tick();
    in_a = 8'h08; in_b = 8'h08;
    #1 chk("bubble_accept2", in_ready, 1);
    tick();
    chk("bubble_full", in_ready, 0);
    chk("bubble_hold_c", out_c, 16'h0019);
    in_valid = 0; out_ready = 1;
    tick();
    chk("bubble_out2", out_c, 16'h0024);
    tick();
    chk("bubble_out3_valid", out_valid, 1);
    chk("bubble_out3", out_c, 16'h0040);
    tick();
    chk("bubble_drained", out_valid, 0);

    in_a = 8'h11; in_b = 8'h11; in_valid = 1;
    tick();
    in_a = 8'h22; in_b = 8'h22;
    tick();
    in_valid = 0;
    tick();
    chk("prereset_valid", out_valid, 1);
    chk("prereset_c", out_c, 16'h0121);
    #2 rst_n = 0;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_c", out_c, 0);
    chk("async_rst_busy", busy, 0);
    #1 rst_n = 1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    tick();
    in_a = 8'h07; in_b = 8'h06; in_valid = 1;
    tick();
    in_valid = 0;
    chk("post_rst_nothing1", out_valid, 0);
    tick();
    chk("post_rst_nothing2", out_valid, 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_c", out_c, 16'h002A);
    tick();
    chk("post_rst_drained", out_valid, 0);

    out_ready1 = 0;
    in_a1 = 16'hFFFF; in_b1 = 16'hFFFF; in_valid1 = 1;
`ifdef FP_MUL_PIPE_TAG_EN
    in_tag1 = 4'hA;
`endif
    #1 chk("s1_in_ready_empty", in_ready1, 1);
    tick();
    in_valid1 = 0;
    chk("s1_out_valid", out_valid1, 1);
    chk("s1_out_c", out_c1, 32'hFFFE0001);
`ifdef FP_MUL_PIPE_TAG_EN
    chk("s1_out_tag", out_tag1, 4'hA);
`endif
    chk("s1_in_ready_stalled", in_ready1, 0);
    tick();
    chk("s1_hold_c", out_c1, 32'hFFFE0001);
    out_ready1 = 1;
    #1 chk("s1_in_ready_xfer", in_ready1, 1);
    tick();
    chk("s1_drained", out_valid1, 0);
    chk("s1_busy", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
